// File: rtl/draw_pkg.sv
// Shared types for the Bresenham line rasteriser (draw_line_multi).
// The default coordinate/counter widths live here so that the top, the clip
// comparator and the bench agree on them.
package draw_pkg;
  localparam int CORDW_DEF = 11;
  localparam int CNTW_DEF  = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    INIT_0 = 2'd1,
    INIT_1 = 2'd2,
    DRAW   = 2'd3
  } draw_state_t;

  typedef logic signed [CORDW_DEF-1:0] coord_t;
  typedef logic signed [CORDW_DEF:0]   err_t;
endpackage

// File: rtl/draw_clip_test.sv
// Inclusive rectangle test for the current pixel. Used by draw_line_multi
// only when DRAW_LINE_MULTI_CLIP_EN is defined.
module draw_clip_test
  import draw_pkg::*;
#(
  parameter int CORDW = CORDW_DEF
) (
  input  logic signed [CORDW-1:0] x_i,
  input  logic signed [CORDW-1:0] y_i,
  input  logic signed [CORDW-1:0] clip_x0_i,
  input  logic signed [CORDW-1:0] clip_y0_i,
  input  logic signed [CORDW-1:0] clip_x1_i,
  input  logic signed [CORDW-1:0] clip_y1_i,
  output logic                    in_clip_o
);
  // Signed, inclusive on all four edges.
  assign in_clip_o = (x_i >= clip_x0_i) && (x_i <= clip_x1_i) &&
                     (y_i >= clip_y0_i) && (y_i <= clip_y1_i);
endmodule

// File: rtl/draw_line_multi.sv
// Bresenham line rasteriser, all octants, stepping from start to end in the
// true direction. Supports polyline continuation (cont_i), abort, a pixel
// counter and, when DRAW_LINE_MULTI_CLIP_EN is defined, a clip window.
//
// Handshake: oe_i is the pixel writer's ready. A pixel transfers in any cycle
// where drawing_o=1 (which already includes oe_i); with oe_i=0 every register
// holds, so the writer can stall for any number of cycles.
module draw_line_multi
  import draw_pkg::*;
#(
  parameter int CORDW = CORDW_DEF,
  parameter int CNTW  = CNTW_DEF
) (
  input  logic                    clk,
  input  logic                    reset_i,
  input  logic                    start_i,
  input  logic                    cont_i,
  input  logic                    abort_i,
  input  logic                    oe_i,
  input  logic signed [CORDW-1:0] x0_i,
  input  logic signed [CORDW-1:0] y0_i,
  input  logic signed [CORDW-1:0] x1_i,
  input  logic signed [CORDW-1:0] y1_i,
  input  logic signed [CORDW-1:0] clip_x0_i,
  input  logic signed [CORDW-1:0] clip_y0_i,
  input  logic signed [CORDW-1:0] clip_x1_i,
  input  logic signed [CORDW-1:0] clip_y1_i,
  output logic signed [CORDW-1:0] x_o,
  output logic signed [CORDW-1:0] y_o,
  output logic                    drawing_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [CNTW-1:0]         count_o,
  output draw_state_t             state_o
);
  // dx/dy need one extra bit; err gets two more so 2*err never overflows.
  localparam int DW = CORDW + 1;
  localparam int EW = CORDW + 3;

  draw_state_t             r_state, w_state_next;
  logic signed [CORDW-1:0] r_xs, r_ys, r_xe, r_ye, r_xl, r_yl, r_x, r_y;
  logic signed [DW-1:0]    r_dx, r_dy;
  logic                    r_sxn, r_syn;
  logic signed [EW-1:0]    r_err;
  logic                    r_done;
  logic [CNTW-1:0]         r_count;

  logic signed [DW-1:0]    w_ddx, w_ddy, w_adx, w_ady;
  logic signed [EW-1:0]    w_dx_e, w_dy_e, w_e2, w_err_next;
  logic                    w_movx, w_movy, w_at_end, w_in_clip, w_drawing;

  // Raw deltas and magnitudes from the captured end points.
  assign w_ddx = {r_xe[CORDW-1], r_xe} - {r_xs[CORDW-1], r_xs};
  assign w_ddy = {r_ye[CORDW-1], r_ye} - {r_ys[CORDW-1], r_ys};
  assign w_adx = w_ddx[DW-1] ? -w_ddx : w_ddx;
  assign w_ady = w_ddy[DW-1] ? -w_ddy : w_ddy;

  // Step decision; both moves are judged on the same err value.
  assign w_dx_e     = {{(EW-DW){r_dx[DW-1]}}, r_dx};
  assign w_dy_e     = {{(EW-DW){r_dy[DW-1]}}, r_dy};
  assign w_e2       = r_err <<< 1;
  assign w_movx     = (w_e2 >= w_dy_e);
  assign w_movy     = (w_e2 <= w_dx_e);
  assign w_err_next = r_err + (w_movx ? w_dy_e : EW'(0)) + (w_movy ? w_dx_e : EW'(0));
  assign w_at_end   = (r_x == r_xe) && (r_y == r_ye);

`ifdef DRAW_LINE_MULTI_CLIP_EN
  draw_clip_test #(.CORDW(CORDW)) u_clip (
    .x_i       (r_x),
    .y_i       (r_y),
    .clip_x0_i (clip_x0_i),
    .clip_y0_i (clip_y0_i),
    .clip_x1_i (clip_x1_i),
    .clip_y1_i (clip_y1_i),
    .in_clip_o (w_in_clip)
  );
`else
  logic w_unused_clip;
  assign w_unused_clip = ^{clip_x0_i, clip_y0_i, clip_x1_i, clip_y1_i};
  assign w_in_clip     = 1'b1;
`endif

  assign w_drawing = (r_state == DRAW) && oe_i && w_in_clip;
  assign drawing_o = w_drawing;
  assign busy_o    = (r_state != IDLE);
  assign done_o    = r_done;
  assign count_o   = r_count;
  assign x_o       = r_x;
  assign y_o       = r_y;
  assign state_o   = r_state;

  // State register.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  // Next state; abort overrides everything outside IDLE, including completion.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start_i || cont_i) w_state_next = INIT_0;
      INIT_0:  w_state_next = INIT_1;
      INIT_1:  w_state_next = DRAW;
      DRAW:    if (oe_i && w_at_end) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    if (abort_i && (r_state != IDLE)) w_state_next = IDLE;
  end

  // Datapath: capture request, set up deltas, then step one pixel per oe_i cycle.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_xs <= '0; r_ys <= '0; r_xe <= '0; r_ye <= '0;
      r_xl <= '0; r_yl <= '0; r_x  <= '0; r_y  <= '0;
      r_dx <= '0; r_dy <= '0; r_sxn <= 1'b0; r_syn <= 1'b0;
      r_err <= '0; r_done <= 1'b0; r_count <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_drawing) r_count <= r_count + CNTW'(1);
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_xs <= x0_i; r_ys <= y0_i; r_xe <= x1_i; r_ye <= y1_i;
            r_count <= '0;
          end else if (cont_i) begin
            r_xs <= r_xl; r_ys <= r_yl; r_xe <= x1_i; r_ye <= y1_i;
            r_count <= '0;
          end
        end
        INIT_0: begin
          r_sxn <= w_ddx[DW-1];
          r_syn <= w_ddy[DW-1];
          r_dx  <= w_adx;
          r_dy  <= -w_ady;
        end
        INIT_1: begin
          r_err <= w_dx_e + w_dy_e;
          r_x   <= r_xs;
          r_y   <= r_ys;
          r_xl  <= r_xe;
          r_yl  <= r_ye;
        end
        DRAW: begin
          if (oe_i && !abort_i) begin
            if (w_at_end) begin
              r_done <= 1'b1;
            end else begin
              r_err <= w_err_next;
              if (w_movx) r_x <= r_sxn ? r_x - CORDW'(1) : r_x + CORDW'(1);
              if (w_movy) r_y <= r_syn ? r_y - CORDW'(1) : r_y + CORDW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule
